// File: rtl/comparator_pkg.sv
// Shared definitions for the comparator and the successive-approximation
// search controller that drives it: default operand width and FSM states.
package comparator_pkg;

  localparam int CMP_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/comparator.sv
// Combinational magnitude comparator: reports a==b, a>b, a<b.
module comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             gt,
  output logic             ls
);

  assign eq = (a == b);
  assign gt = (a > b);
  assign ls = (a < b);

endmodule

// File: rtl/sar_search.sv
// Successive-approximation search controller. Drives a registered probe
// onto a comparator and binary-searches the WIDTH-bit range for the value
// that makes the comparator report equality.
// Optional build macro: SAR_CHECK_EN -- when defined, a cycle in which the
// number of asserted comparator flags is not exactly one aborts the search
// with error=1. When undefined, flags are prioritised eq > gt > ls and
// "no flag" is treated as ls; error is tied to 0.
module sar_search
  import comparator_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          eq,
  input  logic                          gt,
  input  logic                          ls,
  output logic [WIDTH-1:0]              probe,
  output logic                          busy,
  output logic                          done,
  output logic                          found,
  output logic [WIDTH-1:0]              result,
  output logic [$clog2(WIDTH+2)-1:0]    probe_cnt,
  output logic                          error
);

  localparam int CW = $clog2(WIDTH+2);
  // Bounds are one bit wider so lo can reach 2^WIDTH without wrapping.
  localparam int RW = WIDTH + 1;

  state_t          state, state_next;
  logic [RW-1:0]   lo, lo_next;
  logic [RW-1:0]   hi, hi_next;
  logic [WIDTH-1:0] probe_r, probe_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic            found_r, found_next;
  logic [WIDTH-1:0] result_r, result_next;
  logic            error_r, error_next;

  logic [RW-1:0]   probe_ext;
  logic [RW-1:0]   mid_sum;
  logic            flag_fault;

  assign probe_ext = {1'b0, probe_r};

  // Flag-consistency check: exactly one of eq/gt/ls must be asserted.
`ifdef SAR_CHECK_EN
  logic [1:0] flag_cnt;
  assign flag_cnt   = {1'b0, eq} + {1'b0, gt} + {1'b0, ls};
  assign flag_fault = (flag_cnt != 2'd1);
`else
  assign flag_fault = 1'b0;
`endif

  // State and datapath registers; reset returns everything to idle zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lo       <= '0;
      hi       <= '0;
      probe_r  <= '0;
      cnt      <= '0;
      found_r  <= 1'b0;
      result_r <= '0;
      error_r  <= 1'b0;
    end else begin
      state    <= state_next;
      lo       <= lo_next;
      hi       <= hi_next;
      probe_r  <= probe_next;
      cnt      <= cnt_next;
      found_r  <= found_next;
      result_r <= result_next;
      error_r  <= error_next;
    end
  end

  // Next-state logic: narrow [lo,hi] around the probe until eq or empty.
  always_comb begin
    state_next  = state;
    lo_next     = lo;
    hi_next     = hi;
    probe_next  = probe_r;
    cnt_next    = cnt;
    found_next  = found_r;
    result_next = result_r;
    error_next  = error_r;
    mid_sum     = '0;

    case (state)
      IDLE: begin
        if (start) begin
          lo_next     = '0;
          hi_next     = {1'b0, {WIDTH{1'b1}}};
          mid_sum     = {1'b0, {WIDTH{1'b1}}};
          probe_next  = mid_sum[WIDTH:1];
          cnt_next    = CW'(1);
          found_next  = 1'b0;
          result_next = '0;
          error_next  = 1'b0;
          state_next  = PROBE;
        end
      end

      PROBE: begin
        if (flag_fault) begin
          error_next = 1'b1;
          found_next = 1'b0;
          state_next = DONE;
        end else if (eq) begin
          result_next = probe_r;
          found_next  = 1'b1;
          state_next  = DONE;
        end else if (gt) begin
          // New hi = probe-1 falls below lo exactly when probe == lo
          // (the midpoint never lies below lo); this also covers probe 0.
          if (probe_ext == lo) begin
            found_next = 1'b0;
            state_next = DONE;
          end else begin
            hi_next    = probe_ext - RW'(1);
            mid_sum    = lo + hi_next;
            probe_next = mid_sum[WIDTH:1];
            cnt_next   = cnt + CW'(1);
          end
        end else begin
          // ls, or no flag at all when the check is disabled.
          if (probe_ext == hi) begin
            found_next = 1'b0;
            state_next = DONE;
          end else begin
            lo_next    = probe_ext + RW'(1);
            mid_sum    = lo_next + hi;
            probe_next = mid_sum[WIDTH:1];
            cnt_next   = cnt + CW'(1);
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign probe     = probe_r;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign found     = found_r;
  assign result    = result_r;
  assign probe_cnt = cnt;
`ifdef SAR_CHECK_EN
  assign error     = error_r;
`else
  assign error     = 1'b0;
`endif

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search driving a comparator responder.
// A high-level model computes each search's probe sequence and outcome.
module tb_sar_search;
  import comparator_pkg::*;

  localparam int W  = CMP_WIDTH;
  localparam int CW = $clog2(W+2);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  target = '0;
  logic          eq_d, gt_d, ls_d;
  logic          cmp_eq, cmp_gt, cmp_ls;
  logic [W-1:0]  probe;
  logic          busy, done, found, error;
  logic [W-1:0]  result;
  logic [CW-1:0] probe_cnt;
  int            mode = 0;   // 0 honest, 1 always ls, 2 eq+gt, 3 no flags

  int total = 0;
  int passed = 0;

  int exp_q[$];
  int exp_found, exp_res, exp_err;

`ifdef SAR_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  always #5 clk = ~clk;

  comparator #(.WIDTH(W)) u_cmp (
    .a (probe), .b (target), .eq(cmp_eq), .gt(cmp_gt), .ls(cmp_ls)
  );

  sar_search #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .eq(eq_d), .gt(gt_d), .ls(ls_d),
    .probe(probe), .busy(busy), .done(done), .found(found),
    .result(result), .probe_cnt(probe_cnt), .error(error)
  );

  always_comb begin
    eq_d = cmp_eq; gt_d = cmp_gt; ls_d = cmp_ls;
    if (mode == 1) begin eq_d = 1'b0; gt_d = 1'b0; ls_d = 1'b1; end
    else if (mode == 2) begin eq_d = 1'b1; gt_d = 1'b1; ls_d = 1'b0; end
    else if (mode == 3) begin eq_d = 1'b0; gt_d = 1'b0; ls_d = 1'b0; end
  end

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Plain binary search over the integer range, with the responder's
  // behaviour expressed directly per mode.
  task automatic model(input int tgt, input int md);
    int lo, hi, p, e, g, l;
    lo = 0; hi = (1 << W) - 1;
    exp_q.delete();
    exp_found = 0; exp_res = 0; exp_err = 0;
    forever begin
      p = (lo + hi) / 2;
      exp_q.push_back(p);
      case (md)
        0: begin e = int'(p == tgt); g = int'(p > tgt); l = int'(p < tgt); end
        1: begin e = 0; g = 0; l = 1; end
        2: begin e = 1; g = 1; l = 0; end
        default: begin e = 0; g = 0; l = 0; end
      endcase
      if (CHECK && (e + g + l != 1)) begin exp_err = 1; break; end
      if (e != 0) begin exp_found = 1; exp_res = p; break; end
      if (g != 0) hi = p - 1;
      else        lo = p + 1;
      if (lo > hi) break;
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where
  // the DUT is idle again, so calls can be chained back to back.
  task automatic run_search(input int tgt, input int md, input bit pulse);
    int k;
    target = W'(tgt);
    mode   = md;
    model(tgt, md);
    k = exp_q.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < k; i++) begin
      chk($sformatf("probe[%0d]", i), int'(probe), exp_q[i]);
      chk("busy_in_probe", int'(busy), 1);
      chk("done_early", int'(done), 0);
      start = (pulse && i == 1);
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_pulse", int'(done), 1);
    chk("found", int'(found), exp_found);
    chk("result", int'(result), exp_res);
    chk("probe_cnt", int'(probe_cnt), k);
    chk("error", int'(error), exp_err);
    @(negedge clk);
    chk("done_cleared", int'(done), 0);
    chk("busy_cleared", int'(busy), 0);
    chk("found_held", int'(found), exp_found);
    chk("result_held", int'(result), exp_res);
    $display("search target=%0d mode=%0d pulse=%0d probes=%0d found=%0d result=%0d error=%0d",
             tgt, md, pulse, k, found, result, error);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_probe"}, int'(probe), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_found"}, int'(found), 0);
    chk({tag, "_result"}, int'(result), 0);
    chk({tag, "_cnt"}, int'(probe_cnt), 0);
    chk({tag, "_error"}, int'(error), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // Pin the model to hand-computed sequences.
    model(13, 0);
    chk("model13_len", exp_q.size(), 3);
    chk("model13_p1", exp_q[1], 11);
    model(0, 0);
    chk("model0_len", exp_q.size(), 4);
    chk("model0_last", exp_q[3], 0);
    model(15, 0);
    chk("model15_len", exp_q.size(), 5);
    chk("model15_last", exp_q[4], 15);

    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("idle");

    run_search(13, 0, 1'b0);
    chk("t13_result_lit", int'(result), 13);
    chk("t13_cnt_lit", int'(probe_cnt), 3);
    run_search(0, 0, 1'b0);
    chk("t0_cnt_lit", int'(probe_cnt), 4);
    run_search(15, 0, 1'b0);
    chk("t15_result_lit", int'(result), 15);
    chk("t15_cnt_lit", int'(probe_cnt), 5);

    // Lying and silent responders.
    run_search(5, 1, 1'b0);
    chk("liar_found_lit", int'(found), 0);
    run_search(5, 3, 1'b0);
`ifdef SAR_CHECK_EN
    run_search(5, 2, 1'b0);
    chk("eqgt_error_lit", int'(error), 1);
`endif

    // start during PROBE is ignored; back-to-back start after done.
    run_search(9, 0, 1'b1);
    run_search(2, 0, 1'b0);

    // Reset mid-search aborts with no done pulse.
    target = 4'd13; mode = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("pre_rst_busy", int'(busy), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    @(negedge clk);
    chk("midrst_no_done", int'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("post_rst");
    run_search(13, 0, 1'b0);
    chk("after_rst_result_lit", int'(result), 13);

    // Randomized searches with occasional mid-search start pulses.
    for (int n = 0; n < 24; n++) begin
      run_search(int'($urandom_range(0, (1 << W) - 1)), 0, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sar_search.md
# sar_search

Successive-approximation search controller: the driving end of the magnitude comparator interface. It drives a probe value onto a comparator's `a` input and reads back `eq`/`gt`/`ls` against an unknown target on `b`. It binary-searches the WIDTH-bit range until equality and reports the matched value and probe count. It sits in front of the existing combinational comparator, which needs no change.

## Interface

Parameters:
- `WIDTH`, default 4: operand width, matching the comparator's `a`/`b`.

Ports:
- `clk`, input, 1 bit: single clock, rising edge.
- `rst_n`, input, 1 bit: asynchronous, active-low reset.
- `start`, input, 1 bit: begin a search; sampled only in IDLE.
- `eq`, input, 1 bit: comparator result, probe == target.
- `gt`, input, 1 bit: comparator result, probe > target.
- `ls`, input, 1 bit: comparator result, probe < target.
- `probe`, output, WIDTH bits: registered value driven to comparator `a`.
- `busy`, output, 1 bit: search in progress.
- `done`, output, 1 bit: one-cycle pulse when a search ends.
- `found`, output, 1 bit: valid with `done`, held until next `start`; 1 = match.
- `result`, output, WIDTH bits: matched value; held until next `start`.
- `probe_cnt`, output, $clog2(WIDTH+2) bits: probes used in the last search.
- `error`, output, 1 bit: flag-consistency fault (see Configuration).

## Operation

- FSM states: IDLE, PROBE, DONE.
- IDLE, `start`=1:
  - Load lo=0 and hi=2^WIDTH−1 into (WIDTH+1)-bit registers.
  - Set `probe`=(lo+hi)>>1 and `probe_cnt`=1.
  - Clear `found`, `result`, `error`; go to PROBE.
- PROBE: the flags are sampled every clock; `probe` is held stable for that whole cycle. Flag priority is eq > gt > ls:
  - `eq`: `result`=`probe`, `found`=1, go to DONE.
  - `gt`: hi=probe−1.
  - `ls`: lo=probe+1.
  - After a `gt` or `ls` update, if lo>hi: `found`=0, go to DONE. Otherwise `probe`=new mid, `probe_cnt`+1, stay in PROBE.
- The lo/hi registers are one bit wider than WIDTH. probe−1 at 0 and probe+1 at 2^WIDTH−1 therefore set lo>hi without wrap-around.
- DONE: assert `done` for one cycle, then go to IDLE.
- `start` while in PROBE or DONE is ignored.
- `busy`=1 in PROBE and DONE.

## Timing

- Reset values: state IDLE; `probe`=0; `busy`, `done`, `found`, `error` = 0; `result`=0; `probe_cnt`=0.
- Reset asserted mid-search aborts immediately to the reset values; no `done` pulse is produced.
- The comparator path is combinational: `probe` register → comparator → flags → FSM within one cycle.
- Latency is measured from the `start` sample edge to `done` high. With k probes used, latency = k+1 cycles.
- k is at most WIDTH+1; WIDTH=4 gives at most 5 probes.
- `start` can be re-asserted on the cycle after `done` (IDLE).

## Configuration

- `SAR_CHECK_EN` defined:
  - In PROBE, when the number of asserted flags among eq/gt/ls is not exactly one: `error`=1, `found`=0, go to DONE.
  - `error` holds until the next `start`.
- `SAR_CHECK_EN` undefined:
  - No check; the eq > gt > ls priority applies.
  - If no flag is asserted, treat it as `ls`.
  - `error` is tied to 0.

## Structure

- Shared package `comparator_pkg`: FSM state enum (IDLE/PROBE/DONE); default width constant CMP_WIDTH=4.
- No sub-module required.
- The bench instantiates the existing `comparator` as the responder. Its `b` input is driven by a target register in the bench.

## Test plan

- Target 13, WIDTH=4 → probes 7, 11, 13; `found`=1, `result`=13, `probe_cnt`=3; `done` 4 cycles after `start`.
- Target 0 → probes 7, 3, 1, 0; `found`=1, `result`=0, `probe_cnt`=4 (lower-bound edge).
- Target 15 → probes 7, 11, 13, 14, 15; `probe_cnt`=5; no wrap past 15 (upper-bound edge).
- Bench forces a lying responder (`ls` always) → lo passes hi after probe 15; `done`, `found`=0. With `SAR_CHECK_EN`, forcing eq=gt=1 → `error`=1 at the first probe.
- `start` pulsed during PROBE → ignored, search completes unchanged. Back-to-back `start` right after `done` → second search runs.
- `rst_n` low during a search for target 13 → all outputs reset, no `done`. A new `start` after release gives correct result 13.
